// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential Vedic multiplier.
// Holds the nibble/partial-product widths, the FSM state type and the shift helper.
package vedic_pkg;

    localparam int NIBBLE_W = 4;
    localparam int PP_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Bit offset of the partial product for nibble pair (i, j).
    function automatic int unsigned pp_shift(input int unsigned i, input int unsigned j);
        return 32'(NIBBLE_W) * (i + j);
    endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 Vedic (Urdhva-Tiryagbhyam) multiplier built from four 2x2 blocks.
module vedic_4x4
    import vedic_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [PP_W-1:0]     p
);

    // 2x2 Vedic cell: vertical and crosswise terms combined with half adders.
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        logic       cross_a;
        logic       cross_b;
        logic       c1;
        cross_a = x[1] & y[0];
        cross_b = x[0] & y[1];
        c1      = cross_a & cross_b;
        r[0]    = x[0] & y[0];
        r[1]    = cross_a ^ cross_b;
        r[2]    = (x[1] & y[1]) ^ c1;
        r[3]    = (x[1] & y[1]) & c1;
        return r;
    endfunction

    logic [3:0] q0_s;
    logic [3:0] q1_s;
    logic [3:0] q2_s;
    logic [3:0] q3_s;
    logic [4:0] mid_s;

    // Combine the four 2x2 products at their nibble offsets.
    always_comb begin
        q0_s  = vm2(a[1:0], b[1:0]);
        q1_s  = vm2(a[3:2], b[1:0]);
        q2_s  = vm2(a[1:0], b[3:2]);
        q3_s  = vm2(a[3:2], b[3:2]);
        mid_s = {1'b0, q1_s} + {1'b0, q2_s};
        p     = {4'b0000, q0_s} + {1'b0, mid_s, 2'b00} + {q3_s, 4'b0000};
    end

endmodule

// File: rtl/vedic_seq_mul.sv
// Iterative WIDTH x WIDTH unsigned multiplier that reuses one vedic_4x4 core
// over N x N nibble pairs, accumulating shifted partial products.
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               busy
);

    localparam int N      = WIDTH / NIBBLE_W;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    mul_state_t          state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [IDX_W-1:0]    j_q, j_d;

    logic [NIBBLE_W-1:0] a_nib_s;
    logic [NIBBLE_W-1:0] b_nib_s;
    logic [PP_W-1:0]     pp_s;
    logic [PROD_W-1:0]   pp_shifted_s;

    vedic_4x4 u_core (
        .a (a_nib_s),
        .b (b_nib_s),
        .p (pp_s)
    );

    // Nibble mux feeding the core and placement of its product in the accumulator frame.
    always_comb begin
        a_nib_s      = a_q[NIBBLE_W*int'(i_q) +: NIBBLE_W];
        b_nib_s      = b_q[NIBBLE_W*int'(j_q) +: NIBBLE_W];
        pp_shifted_s = PROD_W'(pp_s) << pp_shift(int'(i_q), int'(j_q));
    end

    // Next-state and datapath update: accept, iterate j-inner/i-outer, then hold result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_q + pp_shifted_s;
                if (j_q == IDX_LAST) begin
                    j_d = '0;
                    if (i_q == IDX_LAST) begin
                        i_d     = '0;
                        state_d = DONE;
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = acc_q;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Scoreboard bench for vedic_seq_mul: WIDTH=16 and WIDTH=8 instances checked
// against a plain a*b reference model, including latency and handshake behaviour.
module tb_vedic_seq_mul;

    typedef struct {
        logic [31:0] y;
        time         t;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] y;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
    logic [7:0]  a_8, b_8;
    logic [15:0] y_8;

    exp_t q16[$];
    exp_t q8[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    vedic_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    vedic_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .out_valid(out_valid_8), .out_ready(out_ready_8), .y(y_8), .busy(busy_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor for the 16-bit instance: latency at rise of out_valid, value at handshake.
    initial begin : mon16
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (q16.size() == 0) fail_now("spurious_valid16");
                    else chk("latency16", ($time - q16[0].t - 5) / 10, 64'd16);
                end
                if (out_valid && out_ready) begin
                    if (q16.size() == 0) fail_now("unexpected_out16");
                    else begin
                        e = q16.pop_front();
                        chk("y16", {32'd0, y}, {32'd0, e.y});
                    end
                end
                prev = out_valid;
            end
        end
    end

    // Monitor for the 8-bit instance.
    initial begin : mon8
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid_8 && !prev) begin
                    if (q8.size() == 0) fail_now("spurious_valid8");
                    else chk("latency8", ($time - q8[0].t - 5) / 10, 64'd4);
                end
                if (out_valid_8 && out_ready_8) begin
                    if (q8.size() == 0) fail_now("unexpected_out8");
                    else begin
                        e = q8.pop_front();
                        chk("y8", {48'd0, y_8}, {32'd0, e.y});
                    end
                end
                prev = out_valid_8;
            end
        end
    end

    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, output time t_acc);
        int k;
        k = 0;
        t_acc = 0;
        while (!in_ready && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout16");
            return;
        end
        in_valid = 1'b1; a = av; b = bv;
        @(posedge clk);
        t_acc = $time;
        q16.push_back('{y: {16'd0, av} * {16'd0, bv}, t: $time});
        #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, output time t_acc);
        int k;
        k = 0;
        t_acc = 0;
        while (!in_ready_8 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready_8) begin
            fail_now("accept_timeout8");
            return;
        end
        in_valid_8 = 1'b1; a_8 = av; b_8 = bv;
        @(posedge clk);
        t_acc = $time;
        q8.push_back('{y: {16'd0, {8'd0, av} * {8'd0, bv}}, t: $time});
        #1;
        in_valid_8 = 1'b0; a_8 = 8'($urandom); b_8 = 8'($urandom);
    endtask

    task automatic wait_done16(input bit scramble, input bit rnd_ready);
        for (int k = 0; k < 300; k++) begin
            if (!busy) break;
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom);
            end
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        if (busy) fail_now("done_timeout16");
        out_ready = 1'b1;
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                         input bit scramble, input bit rnd_ready);
        time t;
        issue16(av, bv, t);
        wait_done16(scramble, rnd_ready);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        time         t1, t2;
        logic [31:0] hold;
        int          k;

        rst_n = 1'b1;
        in_valid = 1'b0; a = 16'd0; b = 16'd0; out_ready = 1'b1;
        in_valid_8 = 1'b0; a_8 = 8'd0; b_8 = 8'd0; out_ready_8 = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_y", {32'd0, y}, 64'd0);
        chk("rst_in_ready8", {63'd0, in_ready_8}, 64'd1);
        chk("rst_y8", {48'd0, y_8}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed products.
        run16(16'h0003, 16'h0005, 1'b0, 1'b0);
        chk("y_3x5", {32'd0, y}, 64'h0000000F);
        run16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        chk("y_ffff_sq", {32'd0, y}, 64'hFFFE0001);
        run16(16'h1234, 16'h5678, 1'b0, 1'b0);
        chk("y_1234x5678", {32'd0, y}, 64'h06260060);

        // Random operands, scrambled inputs during RUN, random consumer readiness.
        for (int n = 0; n < 24; n++) begin
            run16(16'($urandom), 16'($urandom), 1'b1, 1'b1);
        end

        // Backpressure in DONE with in_valid pulses that must be ignored.
        out_ready = 1'b0;
        issue16(16'hBEEF, 16'h1357, t1);
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) fail_now("bp_done_timeout");
        hold = y;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_y_stable", {32'd0, y}, {32'd0, hold});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_exit_busy", {63'd0, busy}, 64'd0);
        chk("bp_exit_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_y_held_idle", {32'd0, y}, {32'd0, hold});
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of RUN discards the operation.
        issue16(16'h4321, 16'h8765, t1);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_y", {32'd0, y}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        q16.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run16(16'h0000, 16'hABCD, 1'b0, 1'b0);
        chk("y_0xabcd", {32'd0, y}, 64'd0);

        // Back-to-back on the 8-bit instance with out_ready tied high.
        out_ready_8 = 1'b1;
        issue8(8'h0F, 8'h0F, t1);
        issue8(8'hA5, 8'h5A, t2);
        chk("b2b_interval8", (t2 - t1) / 10, 64'd6);
        k = 0;
        while (busy_8 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy_8) fail_now("done_timeout8");
        chk("y8_a5x5a", {48'd0, y_8}, 64'h3A02);
        for (int n = 0; n < 8; n++) begin
            issue8(8'($urandom), 8'($urandom), t1);
        end

        repeat (20) @(posedge clk);
        #1;
        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
